rename_alloc_ctrl: RTL and testbench

RENAME_ALLOC_CTRL -- requirements
Module: rename_alloc_ctrl

---
 rtl/rename_alloc_ctrl_pkg.sv | 16 +
 rtl/free_list_fifo.sv | 107 ++++++++++
 rtl/rename_alloc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rename_alloc_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared rename definitions: default geometry, index types and allocator FSM states.
package rename_alloc_ctrl_pkg;

    localparam int unsigned DefaultArchCount     = 32;
    localparam int unsigned DefaultPhysAddrCount = 128;
    localparam int unsigned DefaultWritePorts    = 4;

    typedef logic [$clog2(DefaultArchCount)-1:0]     arch_idx_t;
    typedef logic [$clog2(DefaultPhysAddrCount)-1:0] phys_idx_t;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

endpackage

// File: rtl/free_list_fifo.sv
// Multi-push/multi-pop circular free list of physical register indices.
// Storage is never reset; the owner fills it and then loads the full count with fill_done.
module free_list_fifo #(
    parameter int unsigned DEPTH  = 96,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 7,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          sync_rst_n,
    input  logic                          clk_en,
    input  logic                          fill_en,
    input  logic [PTR_W-1:0]              fill_base,
    input  logic [LANES-1:0][DATA_W-1:0]  fill_data,
    input  logic                          fill_done,
    input  logic                          pop_en,
    input  logic [LANES-1:0]              pop_valid,
    output logic [LANES-1:0][DATA_W-1:0]  pop_data,
    input  logic [LANES-1:0]              push_en,
    input  logic [LANES-1:0][DATA_W-1:0]  push_data,
    output logic                          push_drop,
    output logic [CNT_W-1:0]              count
);

    logic [DATA_W-1:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [LANES-1:0][PTR_W-1:0]  pop_idx;
    logic [LANES-1:0][PTR_W-1:0]  push_idx;
    logic [LANES-1:0][PTR_W-1:0]  fill_idx;
    logic [LANES-1:0]             fill_wr;
    int unsigned                  pop_cnt;
    int unsigned                  push_cnt;
    int unsigned                  pops;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return PTR_W'(sum);
    endfunction

    // Lanes are compacted: each active lane takes the next slot after the active lanes below it.
    always_comb begin
        pop_cnt  = 0;
        push_cnt = 0;
        for (int k = 0; k < LANES; k++) begin
            pop_idx[k]  = wrap_add(head_q, pop_cnt);
            pop_data[k] = mem_q[pop_idx[k]];
            if (pop_valid[k]) begin
                pop_cnt = pop_cnt + 1;
            end
            push_idx[k] = wrap_add(tail_q, push_cnt);
            if (push_en[k]) begin
                push_cnt = push_cnt + 1;
            end
            fill_idx[k] = PTR_W'(32'(fill_base) + 32'(k));
            fill_wr[k]  = fill_en && ((32'(fill_base) + 32'(k)) < DEPTH);
        end
    end

    always_comb begin
        pops      = pop_en ? pop_cnt : 32'd0;
        push_drop = (32'(count_q) - pops + push_cnt) > DEPTH;
        head_d    = wrap_add(head_q, pops);
        tail_d    = push_drop ? tail_q : wrap_add(tail_q, push_cnt);
        count_d   = CNT_W'(32'(count_q) - pops + (push_drop ? 32'd0 : push_cnt));
        if (fill_done) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_W'(DEPTH);
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clk_en) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (fill_wr[k]) begin
                    mem_q[fill_idx[k]] <= fill_data[k];
                end
                if (push_en[k] && !push_drop) begin
                    mem_q[push_idx[k]] <= push_data[k];
                end
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename allocator: fills the free list and identity-maps the map table in INIT,
// then grants all-or-nothing rename groups and accepts commit releases in RUN.
module rename_alloc_ctrl
    import rename_alloc_ctrl_pkg::*;
#(
    parameter int unsigned ARCH_COUNT      = DefaultArchCount,
    parameter int unsigned PHYS_ADDR_COUNT = DefaultPhysAddrCount,
    parameter int unsigned WRITE_PORTS     = DefaultWritePorts,
    parameter int unsigned FREE_DEPTH      = PHYS_ADDR_COUNT - ARCH_COUNT,
    localparam int unsigned AW = $clog2(ARCH_COUNT),
    localparam int unsigned PW = $clog2(PHYS_ADDR_COUNT),
    localparam int unsigned CW = $clog2(FREE_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             sync_rst_n,
    input  logic                             clk_en,
    input  logic [WRITE_PORTS-1:0]           req_valid,
    input  logic [WRITE_PORTS-1:0][AW-1:0]   req_arch_addr,
    output logic                             req_ready,
    input  logic [WRITE_PORTS-1:0]           free_en,
    input  logic [WRITE_PORTS-1:0][PW-1:0]   free_phys_addr,
    output logic [WRITE_PORTS-1:0]           wr_en,
    output logic [WRITE_PORTS-1:0][AW-1:0]   tbl_wr_addr,
    output logic [WRITE_PORTS-1:0][PW-1:0]   wr_phys_addr,
    output logic                             init_done,
    output logic [CW-1:0]                    free_count,
    output logic                             overflow_err
);

    localparam int unsigned InitCycles = (FREE_DEPTH + WRITE_PORTS - 1) / WRITE_PORTS;
    localparam int unsigned IdCycles   = ARCH_COUNT / WRITE_PORTS;
    localparam int unsigned IcW        = $clog2(InitCycles + 1);
    localparam int unsigned FpW        = $clog2(FREE_DEPTH);

    state_e                          state_q, state_d;
    logic [IcW-1:0]                  init_cnt_q, init_cnt_d;
    logic [WRITE_PORTS-1:0]          wr_en_q, wr_en_d;
    logic [WRITE_PORTS-1:0][AW-1:0]  tbl_wr_addr_q, tbl_wr_addr_d;
    logic [WRITE_PORTS-1:0][PW-1:0]  wr_phys_addr_q, wr_phys_addr_d;
    logic                            overflow_err_q, overflow_err_d;

    logic                            last_init;
    logic                            run;
    logic                            fill_en;
    logic                            fill_done;
    logic [FpW-1:0]                  fill_base;
    logic [WRITE_PORTS-1:0][PW-1:0]  fill_data;
    logic [WRITE_PORTS-1:0][PW-1:0]  pop_data;
    logic [WRITE_PORTS-1:0]          push_en;
    logic                            push_drop;

    assign last_init = (init_cnt_q == IcW'(InitCycles - 1));

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= StInit;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (last_init) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Readiness compares against the occupancy before this cycle's releases land.
    always_comb begin
        run       = 1'b0;
        req_ready = 1'b0;
        fill_en   = 1'b0;
        fill_done = 1'b0;
        push_en   = '0;
        unique case (state_q)
            StInit: begin
                fill_en   = clk_en;
                fill_done = clk_en && last_init;
            end
            StRun: begin
                run       = 1'b1;
                req_ready = clk_en &&
                            (32'($countones(req_valid)) <= 32'(free_count));
                push_en   = clk_en ? free_en : '0;
            end
            default: ;
        endcase
        init_done = run;
    end

    always_comb begin
        fill_base = FpW'(32'(init_cnt_q) * WRITE_PORTS);
        for (int k = 0; k < WRITE_PORTS; k++) begin
            fill_data[k] = PW'(ARCH_COUNT + 32'(init_cnt_q) * WRITE_PORTS + 32'(k));
        end
    end

    always_comb begin
        init_cnt_d     = init_cnt_q;
        wr_en_d        = '0;
        tbl_wr_addr_d  = tbl_wr_addr_q;
        wr_phys_addr_d = wr_phys_addr_q;
        overflow_err_d = overflow_err_q | push_drop;
        if (!run) begin
            init_cnt_d = init_cnt_q + IcW'(1);
            if (32'(init_cnt_q) < IdCycles) begin
                wr_en_d = '1;
                for (int k = 0; k < WRITE_PORTS; k++) begin
                    tbl_wr_addr_d[k]  = AW'(32'(init_cnt_q) * WRITE_PORTS + 32'(k));
                    wr_phys_addr_d[k] = PW'(32'(init_cnt_q) * WRITE_PORTS + 32'(k));
                end
            end
        end else if (req_ready) begin
            wr_en_d = req_valid;
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (req_valid[k]) begin
                    tbl_wr_addr_d[k]  = req_arch_addr[k];
                    wr_phys_addr_d[k] = pop_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            init_cnt_q     <= '0;
            wr_en_q        <= '0;
            tbl_wr_addr_q  <= '0;
            wr_phys_addr_q <= '0;
            overflow_err_q <= 1'b0;
        end else if (clk_en) begin
            init_cnt_q     <= init_cnt_d;
            wr_en_q        <= wr_en_d;
            tbl_wr_addr_q  <= tbl_wr_addr_d;
            wr_phys_addr_q <= wr_phys_addr_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    free_list_fifo #(
        .DEPTH  (FREE_DEPTH),
        .LANES  (WRITE_PORTS),
        .DATA_W (PW)
    ) u_free_list (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clk_en     (clk_en),
        .fill_en    (fill_en),
        .fill_base  (fill_base),
        .fill_data  (fill_data),
        .fill_done  (fill_done),
        .pop_en     (req_ready),
        .pop_valid  (req_valid),
        .pop_data   (pop_data),
        .push_en    (push_en),
        .push_data  (free_phys_addr),
        .push_drop  (push_drop),
        .count      (free_count)
    );

    assign wr_en        = wr_en_q;
    assign tbl_wr_addr  = tbl_wr_addr_q;
    assign wr_phys_addr = wr_phys_addr_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Random and directed stimulus for rename_alloc_ctrl, checked against a queue-based
// model of the free list and of the set of in-use physical registers.
module tb_rename_alloc_ctrl;

    localparam int WP   = 4;
    localparam int ARCH = 32;
    localparam int PHYS = 128;
    localparam int FD   = PHYS - ARCH;
    localparam int AW   = 5;
    localparam int PW   = 7;
    localparam int CW   = 7;

    logic                    clk = 1'b0;
    logic                    sync_rst_n = 1'b0;
    logic                    clk_en = 1'b1;
    logic [WP-1:0]           req_valid = '0;
    logic [WP-1:0][AW-1:0]   req_arch_addr = '0;
    logic                    req_ready;
    logic [WP-1:0]           free_en = '0;
    logic [WP-1:0][PW-1:0]   free_phys_addr = '0;
    logic [WP-1:0]           wr_en;
    logic [WP-1:0][AW-1:0]   tbl_wr_addr;
    logic [WP-1:0][PW-1:0]   wr_phys_addr;
    logic                    init_done;
    logic [CW-1:0]           free_count;
    logic                    overflow_err;

    rename_alloc_ctrl dut (
        .clk            (clk),
        .sync_rst_n     (sync_rst_n),
        .clk_en         (clk_en),
        .req_valid      (req_valid),
        .req_arch_addr  (req_arch_addr),
        .req_ready      (req_ready),
        .free_en        (free_en),
        .free_phys_addr (free_phys_addr),
        .wr_en          (wr_en),
        .tbl_wr_addr    (tbl_wr_addr),
        .wr_phys_addr   (wr_phys_addr),
        .init_done      (init_done),
        .free_count     (free_count),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: free list as a FIFO of register numbers, pool = registers currently mapped.
    bit            m_run;
    int            m_cyc;
    bit            m_ovf;
    int            fl[$];
    int            pool[$];
    int            rel_log[$];
    logic [WP-1:0] exp_wr_en;
    int            exp_arch[WP];
    int            exp_phys[WP];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ones(input logic [WP-1:0] x);
        int n = 0;
        for (int k = 0; k < WP; k++) if (x[k]) n++;
        return n;
    endfunction

    function automatic logic [WP-1:0][AW-1:0] rand_arch();
        logic [WP-1:0][AW-1:0] a;
        for (int k = 0; k < WP; k++) a[k] = AW'($urandom_range(0, ARCH - 1));
        return a;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_cyc = 0;
        m_ovf = 0;
        fl.delete();
        pool.delete();
        exp_wr_en = '0;
    endtask

    // rel_mode: 0 = random in-use reg, 1 = oldest in-use reg, 2 = fixed reg 5 outside the pool
    task automatic step(input logic [WP-1:0] valid, input logic [WP-1:0][AW-1:0] arch,
                        input logic [WP-1:0] fen_in, input int rel_mode, input logic en);
        logic [WP-1:0]         fen;
        logic [WP-1:0][PW-1:0] fphys;
        int                    taken[$];
        int                    v, idx;
        bit                    from_pool, exp_ready;
        fen = fen_in;
        fphys = '0;
        from_pool = m_run && en && (rel_mode != 2);
        for (int k = 0; k < WP; k++) begin
            if (fen[k]) begin
                if (from_pool) begin
                    if (pool.size() == 0) begin
                        fen[k] = 1'b0;
                    end else begin
                        if (rel_mode == 1) begin
                            v = pool.pop_front();
                        end else begin
                            idx = $urandom_range(0, pool.size() - 1);
                            v = pool[idx];
                            pool.delete(idx);
                        end
                        fphys[k] = PW'(v);
                        taken.push_back(v);
                    end
                end else begin
                    fphys[k] = (rel_mode == 2) ? PW'(5) : PW'($urandom_range(0, PHYS - 1));
                end
            end
        end
        req_valid = valid;
        req_arch_addr = arch;
        free_en = fen;
        free_phys_addr = fphys;
        clk_en = en;
        #1;
        exp_ready = m_run && (ones(valid) <= fl.size());
        if (en) check_eq("req_ready", req_ready, exp_ready);
        if (en) begin
            if (!m_run) begin
                if (m_cyc < ARCH / WP) begin
                    exp_wr_en = '1;
                    for (int k = 0; k < WP; k++) begin
                        exp_arch[k] = m_cyc * WP + k;
                        exp_phys[k] = m_cyc * WP + k;
                    end
                end else begin
                    exp_wr_en = '0;
                end
                m_cyc++;
                if (m_cyc == (FD + WP - 1) / WP) begin
                    m_run = 1;
                    for (int i = ARCH; i < PHYS; i++) fl.push_back(i);
                    for (int i = 0; i < ARCH; i++) pool.push_back(i);
                end
            end else begin
                exp_wr_en = '0;
                if (exp_ready) begin
                    for (int k = 0; k < WP; k++) begin
                        if (valid[k]) begin
                            v = fl.pop_front();
                            exp_wr_en[k] = 1'b1;
                            exp_arch[k] = int'(arch[k]);
                            exp_phys[k] = v;
                            pool.push_back(v);
                        end
                    end
                end
                if (fl.size() + ones(fen) > FD) begin
                    m_ovf = 1;
                    foreach (taken[i]) pool.push_back(taken[i]);
                end else begin
                    for (int k = 0; k < WP; k++) begin
                        if (fen[k]) begin
                            fl.push_back(int'(fphys[k]));
                            rel_log.push_back(int'(fphys[k]));
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("wr_en", wr_en, exp_wr_en);
        for (int k = 0; k < WP; k++) begin
            if (exp_wr_en[k]) begin
                check_eq($sformatf("tbl_wr_addr%0d", k), tbl_wr_addr[k], exp_arch[k]);
                check_eq($sformatf("wr_phys_addr%0d", k), wr_phys_addr[k], exp_phys[k]);
            end
        end
        check_eq("free_count", free_count, m_run ? fl.size() : 0);
        check_eq("init_done", init_done, m_run);
        check_eq("overflow_err", overflow_err, m_ovf);
    endtask

    initial begin
        logic [WP-1:0][AW-1:0] a32;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_free_count", free_count, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_overflow", overflow_err, 0);
        check_eq("rst_ready", req_ready, 0);
        sync_rst_n = 1'b1;

        // INIT with clk_en held high; releases and requests must be ignored
        repeat (24) step(4'($urandom_range(0, 15)), rand_arch(), 4'($urandom_range(0, 15)), 0, 1);
        check_eq("init_done_24", init_done, 1);
        check_eq("free_count_24", free_count, FD);

        // Three-lane group with a hole
        a32[0] = 5'd3;
        a32[1] = 5'd7;
        a32[2] = 5'd0;
        a32[3] = 5'd9;
        step(4'b1011, a32, 4'b0000, 0, 1);
        check_eq("g_wr_en", wr_en, 4'b1011);
        check_eq("g_phys0", wr_phys_addr[0], 32);
        check_eq("g_phys1", wr_phys_addr[1], 33);
        check_eq("g_phys3", wr_phys_addr[3], 34);
        check_eq("g_count", free_count, 93);

        // Random traffic with enable gaps
        repeat (300) step(4'($urandom_range(0, 15)), rand_arch(),
                          4'($urandom_range(0, 15)) & {WP{($urandom_range(0, 2) != 0)}},
                          0, ($urandom_range(0, 9) != 0));
        step(4'b0001, rand_arch(), 4'b0000, 0, 1);

        // Asynchronous reset mid-RUN, away from any clock edge
        #3;
        sync_rst_n = 1'b0;
        #1;
        check_eq("arst_wr_en", wr_en, 0);
        check_eq("arst_free_count", free_count, 0);
        check_eq("arst_init_done", init_done, 0);
        @(posedge clk);
        #1;
        sync_rst_n = 1'b1;
        model_reset();

        // INIT again with random enable gaps, bounded
        for (int i = 0; i < 200 && !m_run; i++) begin
            step(4'($urandom_range(0, 15)), rand_arch(), 4'($urandom_range(0, 15)), 0,
                 ($urandom_range(0, 3) != 0));
        end
        check_eq("reinit_done", init_done, 1);

        // Release into a full list is dropped and the error sticks
        step(4'b0000, rand_arch(), 4'b0001, 2, 1);
        check_eq("ovf_set", overflow_err, 1);
        check_eq("ovf_count", free_count, FD);

        // Drain to 2, then a 4-wide group is refused while two releases land
        repeat (23) step(4'b1111, rand_arch(), 4'b0000, 0, 1);
        step(4'b0011, rand_arch(), 4'b0000, 0, 1);
        check_eq("low_count", free_count, 2);
        step(4'b1111, rand_arch(), 4'b0011, 0, 1);
        check_eq("refuse_wr_en", wr_en, 0);
        check_eq("refuse_count", free_count, 4);
        step(4'b1111, rand_arch(), 4'b0000, 0, 1);
        check_eq("empty_count", free_count, 0);

        // Refill completely in a known order, then allocate across the wrap point
        rel_log.delete();
        repeat (24) step(4'b0000, rand_arch(), 4'b1111, 1, 1);
        check_eq("refill_count", free_count, FD);
        step(4'b1111, rand_arch(), 4'b0000, 0, 1);
        for (int k = 0; k < WP; k++) begin
            check_eq($sformatf("wrap_phys%0d", k), wr_phys_addr[k],
                     (rel_log.size() > k) ? rel_log[k] : -1);
        end
        check_eq("ovf_sticky", overflow_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
